// File: rtl/fft_logpwr.sv
// Converts complex FFT bins into 8-bit log2-power pixels for the spectrogram colormap.
// Tracks bin position per frame, drops the redundant upper half when HALF=1, and flags bin 0.
module fft_logpwr #(
    parameter int          IW     = 16,
    parameter int          LGFFT  = 10,
    parameter int          HALF   = 1,
    parameter int unsigned OFFSET = 0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_ce,
    input  logic            i_sync,
    input  logic [2*IW-1:0] i_sample,
    output logic            o_ce,
    output logic            o_sync,
    output logic [7:0]      o_pixel
);
    // Valid-only stream: i_ce qualifies i_sync/i_sample for one cycle, there is no ready,
    // and o_ce is a one-cycle pulse four clocks after each accepted bin.
    localparam int PW = $clog2(2*IW);
    localparam int LW = PW + 3;

    logic [LGFFT-1:0] cnt, bin;
    logic             synced, accept;

    logic signed [IW-1:0]   re, im;
    logic signed [2*IW-1:0] re_sq, im_sq;

    logic            s1_v, s1_sync;
    logic [2*IW-1:0] s1_re2, s1_im2;
    logic            s2_v, s2_sync;
    logic [2*IW-1:0] s2_p;
    logic [PW-1:0]   s2_msb;
    logic            s3_v, s3_sync, s3_zero;
    logic [PW-1:0]   s3_msb;
    logic [2*IW-2:0] s3_low;

    logic [2*IW+1:0] pad;
    logic [2:0]      frac;
    logic [LW-1:0]   lcode;
    logic [31:0]     lwide;
    logic [7:0]      pix;

    always_comb begin
        bin    = i_sync ? '0 : cnt;
        accept = i_ce && (i_sync || synced) && (HALF == 0 || !bin[LGFFT-1]);
        re     = i_sample[2*IW-1:IW];
        im     = i_sample[IW-1:0];
        re_sq  = re * re;
        im_sq  = im * im;
    end

    // MSB of the power word; the last match in ascending order wins.
    always_comb begin
        s2_msb = '0;
        for (int i = 0; i < 2*IW; i++) begin
            if (s2_p[i]) s2_msb = i[PW-1:0];
        end
    end

    // The three bits below the MSB, zero-filled when the MSB sits near bit 0.
    always_comb begin
        pad  = {s3_low, 3'b000};
        frac = '0;
        for (int i = 0; i < 2*IW; i++) begin
            if (s3_msb == i[PW-1:0]) frac = pad[i+2 -: 3];
        end
        lcode = s3_zero ? '0 : {s3_msb, frac};
        lwide = 32'(lcode);
        if (lwide <= OFFSET)
            pix = '0;
        else if (lwide - OFFSET > 32'd255)
            pix = 8'hFF;
        else
            pix = 8'(lwide - OFFSET);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            synced  <= 1'b0;
            s1_v    <= 1'b0;
            s1_sync <= 1'b0;
            s1_re2  <= '0;
            s1_im2  <= '0;
            s2_v    <= 1'b0;
            s2_sync <= 1'b0;
            s2_p    <= '0;
            s3_v    <= 1'b0;
            s3_sync <= 1'b0;
            s3_zero <= 1'b0;
            s3_msb  <= '0;
            s3_low  <= '0;
            o_ce    <= 1'b0;
            o_sync  <= 1'b0;
            o_pixel <= '0;
        end else begin
            // Discarded bins still move the counter so frame position stays correct.
            if (i_ce) begin
                cnt <= i_sync ? LGFFT'(1) : cnt + 1'b1;
                if (i_sync) synced <= 1'b1;
            end
            s1_v    <= accept;
            s1_sync <= (bin == '0);
            s1_re2  <= re_sq;
            s1_im2  <= im_sq;

            s2_v    <= s1_v;
            s2_sync <= s1_sync;
            s2_p    <= s1_re2 + s1_im2;

            s3_v    <= s2_v;
            s3_sync <= s2_sync;
            s3_zero <= (s2_p == '0);
            s3_msb  <= s2_msb;
            s3_low  <= s2_p[2*IW-2:0];

            o_ce   <= s3_v;
            o_sync <= s3_v && s3_sync;
            if (s3_v) o_pixel <= pix;
        end
    end
endmodule

// File: tb/tb_fft_logpwr.sv
// Bench for fft_logpwr: three instances (half/offset/wide) share one stimulus stream
// and are scored against a plain-arithmetic reference model with cycle-exact timing.
module tb_fft_logpwr;
    localparam int LG = 4;
    localparam int NB = 1 << LG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] re_d = '0;
    logic [15:0] im_d = '0;
    logic [31:0] smp16;
    logic [39:0] smp20;

    logic [2:0]      oce, osy;
    logic [2:0][7:0] opx;

    assign smp16 = {re_d, im_d};
    assign smp20 = {re_d, 4'b0000, im_d, 4'b0000};

    // a: half spectrum, b: full spectrum with offset, c: 20-bit inputs (saturation)
    fft_logpwr #(.IW(16), .LGFFT(LG), .HALF(1), .OFFSET(0)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sync(sync), .i_sample(smp16),
        .o_ce(oce[0]), .o_sync(osy[0]), .o_pixel(opx[0]));
    fft_logpwr #(.IW(16), .LGFFT(LG), .HALF(0), .OFFSET(130)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sync(sync), .i_sample(smp16),
        .o_ce(oce[1]), .o_sync(osy[1]), .o_pixel(opx[1]));
    fft_logpwr #(.IW(20), .LGFFT(LG), .HALF(0), .OFFSET(0)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sync(sync), .i_sample(smp20),
        .o_ce(oce[2]), .o_sync(osy[2]), .o_pixel(opx[2]));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec = ec + 1;

    // ---------------- counters / check ----------------
    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // entry = {due_cycle[31:0], sync, pixel[7:0]}
    logic [40:0] exp_q [3][$];
    string       nm [3] = '{"a", "b", "c"};
    int          m_cnt = 0;
    bit          m_synced = 1'b0;

    function automatic int ref_pixel(longint r, longint i, int offset);
        longint pw = r*r + i*i;
        int p = 0;
        int l;
        if (pw == 0) begin
            l = 0;
        end else begin
            while ((64'sd1 <<< (p+1)) <= pw) p++;
            l = 8*p + (int'((pw*8) / (64'sd1 <<< p)) - 8);
        end
        l = l - offset;
        if (l < 0) l = 0;
        if (l > 255) l = 255;
        return l;
    endfunction

    task automatic model_in(bit s, logic [15:0] r, logic [15:0] i);
        int     bin = s ? 0 : m_cnt;
        longint rr = longint'($signed(r));
        longint ii = longint'($signed(i));
        logic [31:0] due = 32'(ec + 4);
        m_cnt = (bin + 1) % NB;
        if (s) m_synced = 1'b1;
        if (!m_synced) return;
        if (bin < NB/2)
            exp_q[0].push_back({due, bin == 0, 8'(ref_pixel(rr, ii, 0))});
        exp_q[1].push_back({due, bin == 0, 8'(ref_pixel(rr, ii, 130))});
        exp_q[2].push_back({due, bin == 0, 8'(ref_pixel(rr*16, ii*16, 0))});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int k = 0; k < 3; k++) begin
                logic [40:0] e;
                if (exp_q[k].size() > 0 && exp_q[k][0][40:9] == 32'(ec)) begin
                    e = exp_q[k].pop_front();
                    check({"ce_", nm[k]}, oce[k], 1);
                    check({"px_", nm[k]}, opx[k], e[7:0]);
                    check({"sync_", nm[k]}, osy[k], e[8]);
                end else begin
                    check({"spurious_ce_", nm[k]}, oce[k], 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            1:       return 16'($urandom_range(0, 7)) - 16'($urandom_range(0, 3));
            2:       return 16'($urandom);
            default: return 16'($urandom) >> $urandom_range(0, 15);
        endcase
    endfunction

    task automatic send(bit c, bit s, logic [15:0] r, logic [15:0] i);
        @(negedge clk);
        ce = c; sync = s; re_d = r; im_d = i;
        if (c) model_in(s, r, i);
    endtask

    task automatic idle(int n);
        repeat (n) send(1'b0, 1'($urandom_range(0, 1)), rnd16(), rnd16());
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 1'b0;
        #2;
        rst_n = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        m_cnt = 0;
        m_synced = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check({"rst_ce_", nm[k]}, oce[k], 0);
            check({"rst_sync_", nm[k]}, osy[k], 0);
            check({"rst_px_", nm[k]}, opx[k], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // single bin 0 sample, then back-to-back corner bins
        send(1'b1, 1'b1, 16'h0100, 16'h0000);
        send(1'b1, 1'b0, 16'h0003, 16'h0000);
        send(1'b1, 1'b0, 16'h0000, 16'h0000);
        send(1'b1, 1'b0, 16'h8000, 16'h8000);
        send(1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
        send(1'b1, 1'b0, 16'h0001, 16'h0001);
        send(1'b1, 1'b0, 16'h0000, 16'hFFFF);
        idle(6);

        // three full frames with gaps in i_ce
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < NB; b++) begin
                idle($urandom_range(0, 2));
                send(1'b1, b == 0, rnd16(), rnd16());
            end
        idle(6);

        // unsynced samples, then a frame restarted mid-way at bin 5
        do_reset();
        for (int n = 0; n < 5; n++) send(1'b1, 1'b0, rnd16(), rnd16());
        idle(5);
        for (int b = 0; b < 6; b++) send(1'b1, b == 0, rnd16(), rnd16());
        for (int b = 0; b < NB + 4; b++) send(1'b1, b == 0, rnd16(), rnd16());
        idle(6);

        // random stream with occasional syncs and gaps
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'b1, $urandom_range(0, 19) == 0, rnd16(), rnd16());
        end

        // reset with samples in flight, then unsynced input must stay silent
        for (int n = 0; n < 4; n++) send(1'b1, n == 0, rnd16(), rnd16());
        do_reset();
        for (int n = 0; n < 6; n++) send(1'b1, 1'b0, rnd16(), rnd16());
        idle(3);
        send(1'b1, 1'b1, 16'h0100, 16'h0000);
        for (int n = 0; n < 10; n++) send(1'b1, 1'b0, rnd16(), rnd16());
        idle(8);

        for (int k = 0; k < 3; k++) check({"drain_", nm[k]}, exp_q[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
